// File: rtl/bg_copy_engine.sv
// Background copy engine: streams one SRAM background image into OCM,
// one word at a time, with optional end-marker early termination.
//
// state | meaning
// IDLE  | waiting for start
// SETUP | one-cycle settle after base address is latched
// READ  | SRAM read outstanding, waiting for sram_ack
// WRITE | OCM write outstanding, waiting for ocm_ack
// DONE  | copy finished or rejected; held until start drops
module bg_copy_engine #(
  parameter int                DATA_W    = 16,
  parameter int                SRAM_AW   = 20,
  parameter int                OCM_AW    = 19,
  parameter int                NUM_BG    = 4,
  parameter int                IMG_WORDS = 153600,
  parameter int                STRIDE    = 153601,
  parameter bit                MARK_EN   = 1'b1,
  parameter logic [DATA_W-1:0] END_MARK  = DATA_W'(16'hF000),
  localparam int               BGS_W     = (NUM_BG > 1) ? $clog2(NUM_BG) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [BGS_W-1:0]   bg_sel,
  output logic               sram_rd,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [DATA_W-1:0]  sram_data,
  input  logic               sram_ack,
  output logic               ocm_we,
  output logic [OCM_AW-1:0]  ocm_addr,
  output logic [DATA_W-1:0]  ocm_data,
  input  logic               ocm_ack,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [OCM_AW:0]    words_copied
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [OCM_AW:0] IMG_LAST = (OCM_AW+1)'(IMG_WORDS);

  state_t             state_q, state_d;
  logic               bg_ok;
  logic               is_mark;
  logic [SRAM_AW-1:0] base;
  logic [OCM_AW:0]    wc_next;

  assign bg_ok   = 32'(bg_sel) < 32'(NUM_BG);
  assign base    = SRAM_AW'(32'(bg_sel) * 32'(STRIDE));
  assign is_mark = MARK_EN && (sram_data >= END_MARK);
  assign wc_next = words_copied + (OCM_AW+1)'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = bg_ok ? S_SETUP : S_DONE;
      S_SETUP: state_d = abort ? S_IDLE : S_READ;
      S_READ: begin
        if (abort)         state_d = S_IDLE;
        else if (sram_ack) state_d = is_mark ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        if (abort)        state_d = S_IDLE;
        else if (ocm_ack) state_d = (wc_next == IMG_LAST) ? S_DONE : S_READ;
      end
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Abort wins over a coincident ack so counters stay frozen at the last accepted word.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      sram_addr    <= '0;
      ocm_addr     <= '0;
      ocm_data     <= '0;
      words_copied <= '0;
      err          <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (bg_ok) begin
              sram_addr    <= base;
              ocm_addr     <= '0;
              words_copied <= '0;
              err          <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (!abort && sram_ack) ocm_data <= sram_data;
        end
        S_WRITE: begin
          if (!abort && ocm_ack) begin
            sram_addr    <= sram_addr + SRAM_AW'(1);
            ocm_addr     <= ocm_addr + OCM_AW'(1);
            words_copied <= wc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign sram_rd = (state_q == S_READ);
  assign ocm_we  = (state_q == S_WRITE);
  assign busy    = (state_q == S_SETUP) || (state_q == S_READ) || (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_bg_copy_engine.sv
// Directed bench for bg_copy_engine with an 8-word image and 3 backgrounds;
// SRAM/OCM responders with programmable ack latency and transaction logs.
module tb_bg_copy_engine;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  bg_sel = 2'd0;
  logic        sram_rd;
  logic [19:0] sram_addr;
  logic [15:0] sram_data = 16'h0;
  logic        sram_ack = 1'b0;
  logic        ocm_we;
  logic [18:0] ocm_addr;
  logic [15:0] ocm_data;
  logic        ocm_ack = 1'b0;
  logic        busy, done, err;
  logic [19:0] words_copied;

  bg_copy_engine #(.IMG_WORDS(8), .NUM_BG(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort), .bg_sel(bg_sel),
    .sram_rd(sram_rd), .sram_addr(sram_addr), .sram_data(sram_data), .sram_ack(sram_ack),
    .ocm_we(ocm_we), .ocm_addr(ocm_addr), .ocm_data(ocm_data), .ocm_ack(ocm_ack),
    .busy(busy), .done(done), .err(err), .words_copied(words_copied)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // stimulus knobs (written by tests)
  logic [15:0] sram_img[16];
  int cur_base = 0;
  int sram_dly = 0;
  int ocm_dly  = 0;
  int abort_at = 0;

  // responder state and logs (written only by responders)
  int n_rd = 0, n_wr = 0, rd_cyc = 0, we_cyc = 0, stab_err = 0, s_cnt = 0, o_cnt = 0;
  logic [19:0] rd_log[128];
  logic [18:0] wa_log[128];
  logic [15:0] wd_log[128];
  logic [19:0] s_hold;
  logic [18:0] oa_hold;
  logic [15:0] od_hold;
  logic [3:0]  s_idx;

  always @(negedge Clk) begin
    if (sram_rd) begin
      rd_cyc++;
      if (s_cnt == 0) s_hold = sram_addr;
      else if (sram_addr !== s_hold) stab_err++;
      if (s_cnt == sram_dly) begin
        s_idx     = 4'(int'(sram_addr) - cur_base);
        sram_ack  = 1'b1;
        sram_data = sram_img[s_idx];
        if (n_rd < 128) rd_log[n_rd] = sram_addr;
        n_rd++;
        s_cnt = 0;
      end else begin
        sram_ack = 1'b0;
        s_cnt++;
      end
    end else begin
      sram_ack = 1'b0;
      s_cnt    = 0;
    end
  end

  always @(negedge Clk) begin
    if (ocm_we) begin
      we_cyc++;
      if (o_cnt == 0) begin
        oa_hold = ocm_addr;
        od_hold = ocm_data;
      end else if (ocm_addr !== oa_hold || ocm_data !== od_hold) stab_err++;
      if (o_cnt == ocm_dly) begin
        ocm_ack = 1'b1;
        abort   = (abort_at != 0) && (n_wr + 1 == abort_at);
        if (n_wr < 128) begin
          wa_log[n_wr] = ocm_addr;
          wd_log[n_wr] = ocm_data;
        end
        n_wr++;
        o_cnt = 0;
      end else begin
        ocm_ack = 1'b0;
        abort   = 1'b0;
        o_cnt++;
      end
    end else begin
      ocm_ack = 1'b0;
      abort   = 1'b0;
      o_cnt   = 0;
    end
  end

  task automatic test_reset();
    Reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge Clk);
    tests++;
    if ({sram_rd, ocm_we, busy, done, err} !== 5'b0 || sram_addr !== 20'd0 ||
        ocm_addr !== 19'd0 || ocm_data !== 16'd0 || words_copied !== 20'd0) begin
      fails++;
      $display("FAIL reset_values: rd=%b we=%b busy=%b done=%b err=%b sa=%0d oa=%0d od=%h wc=%0d, required all zero",
               sram_rd, ocm_we, busy, done, err, sram_addr, ocm_addr, ocm_data, words_copied);
    end
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic_copy();
    int rd0, wr0, cyc, bad;
    rd0 = n_rd; wr0 = n_wr;
    cur_base = 153601; sram_dly = 0; ocm_dly = 0;
    for (int k = 0; k < 16; k++) sram_img[k] = 16'(k + 1);
    bg_sel = 2'd1;
    start  = 1'b1;
    @(negedge Clk);
    tests++;
    if (busy !== 1'b1 || sram_rd !== 1'b0) begin
      fails++;
      $display("FAIL setup_cycle: busy=%b sram_rd=%b, required 1 0", busy, sram_rd);
    end
    @(negedge Clk);
    cyc = 2;
    tests++;
    if (sram_rd !== 1'b1 || sram_addr !== 20'd153601) begin
      fails++;
      $display("FAIL first_read: sram_rd=%b addr=%0d, required 1 153601", sram_rd, sram_addr);
    end
    while (!done && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    tests++;
    if (cyc !== 18) begin
      fails++;
      $display("FAIL basic_latency: done after %0d cycles, required 18", cyc);
    end
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || words_copied !== 20'd8) begin
      fails++;
      $display("FAIL basic_status: done=%b err=%b wc=%0d, required 1 0 8", done, err, words_copied);
    end
    bad = 0;
    if (n_rd - rd0 != 8 || n_wr - wr0 != 8) bad++;
    for (int i = 0; i < 8; i++) begin
      if (rd_log[rd0+i] !== 20'(153601 + i)) bad++;
      if (wa_log[wr0+i] !== 19'(i)) bad++;
      if (wd_log[wr0+i] !== 16'(i + 1)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL basic_transfers: %0d bad entries (reads=%0d writes=%0d), required 0 bad, 8 reads 8 writes",
               bad, n_rd - rd0, n_wr - wr0);
    end
    repeat (2) @(negedge Clk);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL done_hold: done=%b with start high, required 1", done);
    end
    start = 1'b0;
    @(negedge Clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_release: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_end_mark();
    int wr0, cyc;
    wr0 = n_wr;
    cur_base = 0; sram_dly = 0; ocm_dly = 0;
    for (int k = 0; k < 16; k++) sram_img[k] = 16'(k + 1);
    sram_img[2] = 16'hF000;
    bg_sel = 2'd0;
    start  = 1'b1;
    cyc = 0;
    @(negedge Clk);
    while (!done && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || words_copied !== 20'd2 || n_wr - wr0 != 2) begin
      fails++;
      $display("FAIL end_mark: done=%b err=%b wc=%0d writes=%0d, required 1 0 2 2",
               done, err, words_copied, n_wr - wr0);
    end
    tests++;
    if (wa_log[wr0+1] !== 19'd1 || ocm_data !== 16'hF000) begin
      fails++;
      $display("FAIL end_mark_data: last_wa=%0d ocm_data=%h, required 1 f000", wa_log[wr0+1], ocm_data);
    end
    start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_bad_bg();
    int rc0, wc0;
    rc0 = rd_cyc; wc0 = we_cyc;
    bg_sel = 2'd3;
    start  = 1'b1;
    @(negedge Clk);
    tests++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bad_bg_status: done=%b err=%b busy=%b, required 1 1 0", done, err, busy);
    end
    repeat (4) @(negedge Clk);
    tests++;
    if (rd_cyc != rc0 || we_cyc != wc0 || done !== 1'b1) begin
      fails++;
      $display("FAIL bad_bg_no_access: rd_cycles=%0d we_cycles=%0d done=%b, required 0 0 1",
               rd_cyc - rc0, we_cyc - wc0, done);
    end
    start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_delayed_acks();
    int rd0, wr0, st0, cyc, bad;
    rd0 = n_rd; wr0 = n_wr; st0 = stab_err;
    cur_base = 307202; sram_dly = 3; ocm_dly = 2;
    for (int k = 0; k < 16; k++) sram_img[k] = 16'(k * 257 + 16'h0A00);
    bg_sel = 2'd2;
    start  = 1'b1;
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge Clk);
      cyc++;
    end
    tests++;
    if (cyc !== 58 || words_copied !== 20'd8 || err !== 1'b0) begin
      fails++;
      $display("FAIL delayed_status: cycles=%0d wc=%0d err=%b, required 58 8 0", cyc, words_copied, err);
    end
    bad = 0;
    if (n_rd - rd0 != 8 || n_wr - wr0 != 8) bad++;
    for (int i = 0; i < 8; i++) begin
      if (rd_log[rd0+i] !== 20'(307202 + i)) bad++;
      if (wa_log[wr0+i] !== 19'(i)) bad++;
      if (wd_log[wr0+i] !== 16'(i * 257 + 16'h0A00)) bad++;
    end
    tests++;
    if (bad != 0 || stab_err != st0) begin
      fails++;
      $display("FAIL delayed_transfers: bad=%0d unstable=%0d, required 0 0", bad, stab_err - st0);
    end
    start = 1'b0; sram_dly = 0; ocm_dly = 0;
    @(negedge Clk);
  endtask

  task automatic test_abort();
    int wr0, wc0, cyc;
    wr0 = n_wr;
    cur_base = 153601;
    for (int k = 0; k < 16; k++) sram_img[k] = 16'(k + 1);
    abort_at = wr0 + 4;
    bg_sel = 2'd1;
    start  = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    cyc = 1;
    while (busy && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    tests++;
    if (cyc !== 10 || done !== 1'b0 || words_copied !== 20'd3 || ocm_addr !== 19'd3 ||
        sram_addr !== 20'd153604 || n_wr - wr0 != 4) begin
      fails++;
      $display("FAIL abort_freeze: cyc=%0d done=%b wc=%0d oa=%0d sa=%0d acks=%0d, required 10 0 3 3 153604 4",
               cyc, done, words_copied, ocm_addr, sram_addr, n_wr - wr0);
    end
    abort_at = 0;
    wc0 = we_cyc;
    repeat (5) @(negedge Clk);
    tests++;
    if (we_cyc != wc0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_more_writes: we_cycles=%0d busy=%b, required 0 0", we_cyc - wc0, busy);
    end
  endtask

  task automatic test_restart_after_abort();
    int rd0, wr0, cyc, bad;
    rd0 = n_rd; wr0 = n_wr;
    bg_sel = 2'd1;
    start  = 1'b1;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    bad = 0;
    if (n_rd - rd0 != 8 || n_wr - wr0 != 8) bad++;
    for (int i = 0; i < 8; i++) begin
      if (rd_log[rd0+i] !== 20'(153601 + i)) bad++;
      if (wa_log[wr0+i] !== 19'(i)) bad++;
      if (wd_log[wr0+i] !== 16'(i + 1)) bad++;
    end
    tests++;
    if (bad != 0 || words_copied !== 20'd8 || done !== 1'b1) begin
      fails++;
      $display("FAIL restart_copy: bad=%0d wc=%0d done=%b, required 0 8 1", bad, words_copied, done);
    end
    start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_write();
    int rd0, wr0, cyc;
    ocm_dly = 2;
    bg_sel  = 2'd1;
    start   = 1'b1;
    cyc = 0;
    while (!ocm_we && cyc < 20) begin
      @(negedge Clk);
      cyc++;
    end
    tests++;
    if (ocm_we !== 1'b1) begin
      fails++;
      $display("FAIL reach_write: ocm_we=%b after %0d cycles, required 1", ocm_we, cyc);
    end
    wr0 = n_wr;
    Reset_n = 1'b0;
    @(negedge Clk);
    tests++;
    if ({sram_rd, ocm_we, busy, done, err} !== 5'b0 || sram_addr !== 20'd0 ||
        ocm_addr !== 19'd0 || ocm_data !== 16'd0 || words_copied !== 20'd0 || n_wr != wr0) begin
      fails++;
      $display("FAIL reset_mid_write: rd=%b we=%b busy=%b done=%b err=%b sa=%0d oa=%0d od=%h wc=%0d acks=%0d, required all zero",
               sram_rd, ocm_we, busy, done, err, sram_addr, ocm_addr, ocm_data, words_copied, n_wr - wr0);
    end
    rd0 = n_rd; wr0 = n_wr;
    Reset_n = 1'b1;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge Clk);
      cyc++;
    end
    tests++;
    if (rd_log[rd0] !== 20'd153601 || words_copied !== 20'd8 || n_wr - wr0 != 8 || wa_log[wr0] !== 19'd0) begin
      fails++;
      $display("FAIL restart_after_reset: first_rd=%0d wc=%0d writes=%0d first_wa=%0d, required 153601 8 8 0",
               rd_log[rd0], words_copied, n_wr - wr0, wa_log[wr0]);
    end
    start = 1'b0; ocm_dly = 0;
    @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_end_mark();
    test_bad_bg();
    test_delayed_acks();
    test_abort();
    test_restart_after_abort();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
